// File: rtl/serdiv_label_unit_if.sv
// rtl/serdiv_label_unit_if.sv - request/response handshake bundle for the label-tracking serial divider
interface serdiv_label_unit_if #(
    parameter int WIDTH = 8,
    parameter int ID_W  = 3
);
    logic [ID_W-1:0]  id_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic [1:0]       opcode_i;
    logic             op_a_i_label;
    logic             op_b_i_label;
    logic             in_vld_i;
    logic             in_rdy_o;
    logic             out_vld_o;
    logic             out_rdy_i;
    logic [ID_W-1:0]  id_o;
    logic [WIDTH-1:0] res_o;
    logic             res_o_label;

    modport master (
        output id_i, op_a_i, op_b_i, opcode_i, op_a_i_label, op_b_i_label,
               in_vld_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, id_o, res_o, res_o_label
    );

    modport slave (
        input  id_i, op_a_i, op_b_i, opcode_i, op_a_i_label, op_b_i_label,
               in_vld_i, out_rdy_i,
        output in_rdy_o, out_vld_o, id_o, res_o, res_o_label
    );
endinterface

// File: rtl/serdiv_label_unit.sv
// rtl/serdiv_label_unit.sv - fixed-latency restoring radix-2 divider with taint-label propagation
module serdiv_label_unit #(
    parameter int WIDTH = 8,
    parameter int ID_W  = 3     // ariane TRANS_ID_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    serdiv_label_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             label_q, label_d;
    logic             is_rem_q, is_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             step_ge;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign bus.in_rdy_o    = (state_q == IDLE) && !flush_i;
    assign bus.out_vld_o   = (state_q == FINISH);
    assign bus.res_o       = res_q;
    assign bus.id_o        = id_q;
    assign bus.res_o_label = label_q;

    assign accept = bus.in_vld_i && bus.in_rdy_o;
    assign a_neg  = bus.opcode_i[0] && bus.op_a_i[WIDTH-1];
    assign b_neg  = bus.opcode_i[0] && bus.op_b_i[WIDTH-1];

    // The quotient register doubles as the dividend shifter; its MSB feeds the partial remainder.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign step_ge   = (rem_shift >= {1'b0, div_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - div_q;

    // Signed overflow needs no special path: |MIN|/1 with equal signs yields MIN, remainder 0.
    always_comb begin
        q_fix = q_neg_q ? (~quot_q + 1'b1) : quot_q;
        r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (div0_q) begin
            q_fix = '1;
            r_fix = a_raw_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        div_d    = div_q;
        a_raw_d  = a_raw_q;
        res_d    = res_q;
        id_d     = id_q;
        label_d  = label_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        div0_d   = div0_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    quot_d   = a_neg ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
                    div_d    = b_neg ? (~bus.op_b_i + 1'b1) : bus.op_b_i;
                    rem_d    = '0;
                    cnt_d    = '0;
                    a_raw_d  = bus.op_a_i;
                    id_d     = bus.id_i;
                    label_d  = bus.op_a_i_label | bus.op_b_i_label;
                    is_rem_d = bus.opcode_i[1];
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    div0_d   = (bus.op_b_i == '0);
                    state_d  = DIVIDE;
                end
            end
            DIVIDE: begin
                // WIDTH shift/subtract steps, then one cycle to apply sign and special-case fixups.
                if (cnt_q != CNT_W'(WIDTH)) begin
                    rem_d  = step_ge ? rem_sub : rem_shift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], step_ge};
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    res_d   = is_rem_q ? r_fix : q_fix;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (bus.out_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            a_raw_q  <= '0;
            res_q    <= '0;
            id_q     <= '0;
            label_q  <= 1'b0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            a_raw_q  <= a_raw_d;
            res_q    <= res_d;
            id_q     <= id_d;
            label_q  <= label_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            div0_q   <= div0_d;
        end
    end
endmodule

// File: tb/tb_serdiv_label_unit.sv
// tb/tb_serdiv_label_unit.sv - directed self-checking bench for serdiv_label_unit
module tb_serdiv_label_unit;
    logic clk;
    logic rst_n;
    logic flush;
    int   n_chk;
    int   n_pass;

    serdiv_label_unit_if #(.WIDTH(8), .ID_W(3)) bus ();

    serdiv_label_unit #(.WIDTH(8), .ID_W(3)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic start(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                         input logic la, input logic lb, input logic [2:0] id);
        @(negedge clk);
        bus.opcode_i     = opc;
        bus.op_a_i       = a;
        bus.op_b_i       = b;
        bus.op_a_i_label = la;
        bus.op_b_i_label = lb;
        bus.id_i         = id;
        bus.in_vld_i     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_vld_i = 1'b0;
        bus.op_a_i   = 8'hA5;
        bus.op_b_i   = 8'h5A;
        bus.id_i     = 3'd7;
    endtask

    task automatic do_op(input string tag, input logic [1:0] opc, input logic [7:0] a,
                         input logic [7:0] b, input logic la, input logic lb,
                         input logic [2:0] id, input logic [7:0] er, input logic el);
        int n;
        bit got;
        bus.out_rdy_i = 1'b1;
        start(opc, a, b, la, lb, id);
        n = 0;
        got = 0;
        while (n < 20 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_vld_o) got = 1;
        end
        check({tag, " latency"}, 64'(n), 64'd9);
        check({tag, " res"}, 64'(bus.res_o), 64'(er));
        check({tag, " label"}, 64'(bus.res_o_label), 64'(el));
        check({tag, " id"}, 64'(bus.id_o), 64'(id));
        @(posedge clk);
        #1;
        check({tag, " vld_drop"}, 64'(bus.out_vld_o), 64'd0);
        check({tag, " rdy_back"}, 64'(bus.in_rdy_o), 64'd1);
    endtask

    initial begin
        int seen;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.id_i = '0; bus.op_a_i = '0; bus.op_b_i = '0; bus.opcode_i = '0;
        bus.op_a_i_label = 1'b0; bus.op_b_i_label = 1'b0;
        bus.in_vld_i = 1'b0; bus.out_rdy_i = 1'b1;

        #12;
        check("rst in_rdy", 64'(bus.in_rdy_o), 64'd1);
        check("rst out_vld", 64'(bus.out_vld_o), 64'd0);
        check("rst res", 64'(bus.res_o), 64'd0);
        check("rst id", 64'(bus.id_o), 64'd0);
        check("rst label", 64'(bus.res_o_label), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("udiv00", 2'd0, 8'h20, 8'h20, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0);
        do_op("udiv10", 2'd0, 8'h20, 8'h20, 1'b1, 1'b0, 3'd2, 8'h01, 1'b1);
        do_op("udiv01", 2'd0, 8'h20, 8'h20, 1'b0, 1'b1, 3'd3, 8'h01, 1'b1);
        do_op("udiv11", 2'd0, 8'h20, 8'h20, 1'b1, 1'b1, 3'd4, 8'h01, 1'b1);
        do_op("div_neg", 2'd1, 8'hF9, 8'h02, 1'b0, 1'b0, 3'd5, 8'hFD, 1'b0);
        do_op("rem_neg", 2'd3, 8'hF9, 8'h02, 1'b1, 1'b0, 3'd6, 8'hFF, 1'b1);
        do_op("udiv_z", 2'd0, 8'h20, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0);
        do_op("urem_z", 2'd2, 8'h20, 8'h00, 1'b0, 1'b1, 3'd1, 8'h20, 1'b1);
        do_op("div_z", 2'd1, 8'hF9, 8'h00, 1'b0, 1'b0, 3'd2, 8'hFF, 1'b0);
        do_op("rem_z", 2'd3, 8'hF9, 8'h00, 1'b0, 1'b0, 3'd3, 8'hF9, 1'b0);
        do_op("div_ovf", 2'd1, 8'h80, 8'hFF, 1'b0, 1'b0, 3'd4, 8'h80, 1'b0);
        do_op("rem_ovf", 2'd3, 8'h80, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h00, 1'b1);
        do_op("urem", 2'd2, 8'h64, 8'h07, 1'b0, 1'b0, 3'd6, 8'h02, 1'b0);
        do_op("div_pn", 2'd1, 8'h64, 8'hF9, 1'b0, 1'b0, 3'd7, 8'hF2, 1'b0);

        // Consumer stall in FINISH
        bus.out_rdy_i = 1'b0;
        start(2'd0, 8'h64, 8'h07, 1'b0, 1'b0, 3'd5);
        seen = 0;
        while (seen < 20 && !bus.out_vld_o) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("stall latency", 64'(seen), 64'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall vld", 64'(bus.out_vld_o), 64'd1);
            check("stall res", 64'(bus.res_o), 64'h0E);
            check("stall id", 64'(bus.id_o), 64'd5);
            check("stall rdy", 64'(bus.in_rdy_o), 64'd0);
        end
        bus.out_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        check("stall release", 64'(bus.out_vld_o), 64'd0);

        // Flush on the third DIVIDE cycle
        start(2'd0, 8'h20, 8'h20, 1'b0, 1'b0, 3'd6);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush rdy_low", 64'(bus.in_rdy_o), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush vld", 64'(bus.out_vld_o), 64'd0);
        check("flush rdy", 64'(bus.in_rdy_o), 64'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_vld_o) seen++;
        end
        check("flush no_result", 64'(seen), 64'd0);

        // Flush together with a request in IDLE must not accept it
        @(negedge clk);
        flush = 1'b1;
        bus.in_vld_i = 1'b1;
        bus.id_i = 3'd3;
        #1;
        check("flush_req rdy", 64'(bus.in_rdy_o), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_vld_i = 1'b0;
        #1;
        check("flush_req idle", 64'(bus.in_rdy_o), 64'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_vld_o) seen++;
        end
        check("flush_req no_result", 64'(seen), 64'd0);

        // Reset mid-DIVIDE
        start(2'd1, 8'hF9, 8'h02, 1'b1, 1'b1, 3'd4);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst rdy", 64'(bus.in_rdy_o), 64'd1);
        check("midrst vld", 64'(bus.out_vld_o), 64'd0);
        check("midrst res", 64'(bus.res_o), 64'd0);
        check("midrst id", 64'(bus.id_o), 64'd0);
        check("midrst label", 64'(bus.res_o_label), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 2'd3, 8'hF9, 8'h02, 1'b0, 1'b1, 3'd2, 8'hFF, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
